// File: rtl/ram_dma_initiator_pkg.sv
// Shared types and constants for the RAM DMA initiator.
// Status codes are held on status_o until the next accepted start.
package ram_dma_initiator_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_RD,
        DMA_WR,
        DMA_DONE
    } dma_state_e;

    localparam logic [1:0] DMA_ST_OK    = 2'b00;
    localparam logic [1:0] DMA_ST_ABORT = 2'b01;
    localparam logic [1:0] DMA_ST_ALIGN = 2'b10;
    localparam logic [1:0] DMA_ST_RANGE = 2'b11;

    // Buffer index width; a single-entry buffer still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage

// File: rtl/ram_dma_initiator_if.sv
// Single RAM port (en/we/addr/data) between the DMA initiator and a RAM_mem port.
interface ram_dma_initiator_if #(
    parameter int unsigned AW = 16
);
    logic          mem_en_o;
    logic [3:0]    mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic [31:0]   mem_data_i;

    modport master (
        output mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
        input  mem_data_i
    );

    modport slave (
        input  mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
        output mem_data_i
    );
endinterface

// File: rtl/ram_dma_initiator_burst_buf.sv
// BURST x 32 register file holding one read burst until it is written back.
module dma_burst_buf #(
    parameter int unsigned BURST = 4,
    parameter int unsigned IW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem_q [BURST];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BURST; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb rdata = mem_q[raddr];
endmodule

// File: rtl/ram_dma_initiator.sv
// Burst memcpy initiator on one RAM port: reads up to BURST words into a local
// buffer, writes them to the destination, repeats until len words are copied.
module ram_dma_initiator
    import ram_dma_initiator_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = 65536,
    parameter int unsigned BURST     = 4,
    parameter int unsigned LEN_W     = 16,
    localparam int unsigned AW       = $clog2(MEM_WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [AW-1:0]    src_i,
    input  logic [AW-1:0]    dst_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    ram_dma_initiator_if.master mem
);
    localparam int unsigned IW = idx_width(BURST);
    localparam int unsigned CW = AW + LEN_W + 2;
    localparam logic [CW-1:0] MEM_LIMIT = CW'(MEM_WIDTH);

    dma_state_e       state_q, state_d;
    logic [AW-1:0]    src_ptr_q, dst_ptr_q;
    logic [LEN_W-1:0] rem_q;
    logic [IW-1:0]    idx_q, last_q;
    logic [1:0]       status_q;
    logic [31:0]      buf_rdata;
    logic             misaligned, out_of_range, rd_last, wr_last;

    // End addresses are evaluated wide enough that neither sum can overflow.
    always_comb begin
        misaligned   = (src_i[1:0] != 2'b00) || (dst_i[1:0] != 2'b00);
        out_of_range = ((CW'(src_i) + (CW'(len_i) << 2)) > MEM_LIMIT) ||
                       ((CW'(dst_i) + (CW'(len_i) << 2)) > MEM_LIMIT);
        rd_last      = (idx_q == IW'(BURST - 1)) || (rem_q == LEN_W'(1));
        wr_last      = (idx_q == last_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= DMA_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        mem.mem_en_o   = 1'b0;
        mem.mem_we_o   = '0;
        mem.mem_addr_o = '0;
        mem.mem_data_o = '0;
        case (state_q)
            DMA_IDLE: begin
                if (start_i) begin
                    if (misaligned || out_of_range || (len_i == '0)) state_d = DMA_DONE;
                    else                                             state_d = DMA_RD;
                end
            end
            DMA_RD: begin
                busy_o         = 1'b1;
                mem.mem_en_o   = 1'b1;
                mem.mem_addr_o = src_ptr_q;
                if (abort_i)      state_d = DMA_DONE;
                else if (rd_last) state_d = DMA_WR;
            end
            DMA_WR: begin
                busy_o         = 1'b1;
                mem.mem_en_o   = 1'b1;
                mem.mem_we_o   = '1;
                mem.mem_addr_o = dst_ptr_q;
                mem.mem_data_o = buf_rdata;
                if (abort_i)      state_d = DMA_DONE;
                else if (wr_last) state_d = (rem_q == '0) ? DMA_DONE : DMA_RD;
            end
            DMA_DONE: begin
                done_o  = 1'b1;
                state_d = DMA_IDLE;
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    // last_q remembers the final index of the read phase so WR replays the same count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            status_q  <= DMA_ST_OK;
        end else begin
            case (state_q)
                DMA_IDLE: begin
                    if (start_i) begin
                        src_ptr_q <= src_i;
                        dst_ptr_q <= dst_i;
                        rem_q     <= len_i;
                        idx_q     <= '0;
                        if (misaligned)        status_q <= DMA_ST_ALIGN;
                        else if (out_of_range) status_q <= DMA_ST_RANGE;
                        else                   status_q <= DMA_ST_OK;
                    end
                end
                DMA_RD: begin
                    src_ptr_q <= src_ptr_q + AW'(4);
                    rem_q     <= rem_q - LEN_W'(1);
                    if (rd_last) begin
                        last_q <= idx_q;
                        idx_q  <= '0;
                    end else begin
                        idx_q  <= idx_q + IW'(1);
                    end
                    if (abort_i) status_q <= DMA_ST_ABORT;
                end
                DMA_WR: begin
                    dst_ptr_q <= dst_ptr_q + AW'(4);
                    idx_q     <= wr_last ? '0 : idx_q + IW'(1);
                    if (abort_i) status_q <= DMA_ST_ABORT;
                end
                default: ;
            endcase
        end
    end

    always_comb status_o = status_q;

    dma_burst_buf #(
        .BURST (BURST),
        .IW    (IW)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (state_q == DMA_RD),
        .waddr (idx_q),
        .wdata (mem.mem_data_i),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );
endmodule
